mfp_ahb_uart_slave: RTL and testbench
=====================================

# mfp_ahb_uart_slave

AHB-Lite slave providing an 8N1 UART, occupying a fourth slot on the matrix alongside reset RAM, RAM and GPIO. It is driven by the matrix with its own decoded HSEL and returns HRDATA/HREADY/HRESP into the response mux. It replaces the tied-off UART_TX path with a real transmitter and receiver.

## Interface
- DEFAULT_DIV, 434 — reset value of DIVISOR (HCLK cycles per bit; 50 MHz / 115200).
- RX_FIFO_AW, 2 — log2 of RX FIFO depth (default 4 entries).
- Clock and reset: one clock; reset is synchronous and active-low.
- HCLK  in  1  system clock; all state updates on rising edge.
- HRESETn  in  1  synchronous active-low reset.
- HADDR  in  32  address; only [3:2] decoded.
- HBURST, HMASTLOCK, HPROT, HSIZE  in  3/1/4/3  accepted, unused.
- HSEL  in  1  slave select from matrix decoder.
- HTRANS  in  2  transfer valid when HTRANS[1]=1.
- HWDATA  in  32  write data, data phase.
- HWRITE  in  1  write strobe, address phase.
- HRDATA  out  32  read data, data phase.
- HREADY  out  1  constant 1 (zero wait state).
- HRESP  out  1  constant 0 (OKAY).
- SI_Endian  in  1  accepted, unused.
- UART_RX  in  1  asynchronous serial input.
- UART_TX  out  1  serial output, idle high.

## Operation
- Registers (word offsets, HADDR[3:2]): 0 DATA — write: TX byte from HWDATA[7:0]; read: RX FIFO head in [7:0], pop. 1 STATUS — [0] tx_ready (holding register empty), [1] rx_valid (FIFO non-empty), [2] rx_overrun (sticky), [3] frame_err (sticky), [4] tx_busy (shifter active); write 1 to [2]/[3] clears. 2 DIVISOR — [15:0] R/W. 3 — reads 0, writes ignored. Unused bits read 0.
- Address phase accepted when HSEL & HTRANS[1]; address/HWRITE registered.
- Read: HRDATA registered at end of address phase; DATA pop occurs at the same edge. Read of DATA with FIFO empty returns 0, no pop.
- Write: applied at end of data phase from HWDATA. Read immediately following a write to the same register returns the pre-write value.
- DIVISOR writes below 16 store 16.
- TX: holding register + shift register (double-buffered). Write to DATA when tx_ready=0 is dropped. FSM IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE (or START if holding full). Each bit lasts DIVISOR cycles; bit counter reloads from DIVISOR at each bit start, so DIVISOR changes take effect at the next bit.
- RX: 2-flop synchronizer. IDLE detects 1→0; after DIVISOR/2 cycles re-samples: 1 → back to IDLE (glitch), 0 → DATA. Samples 8 bits every DIVISOR cycles, then stop bit. Stop=0: frame_err set, byte discarded. Stop=1: push; if FIFO full and no pop same cycle, byte dropped, rx_overrun set. Push and pop in the same cycle when full: both occur, no overrun.
- Reset mid-frame aborts both FSMs; FIFO emptied; DIVISOR=DEFAULT_DIV.

## Timing
- Reset values: HRDATA=0, HREADY=1, HRESP=0, UART_TX=1, STATUS=0x01.
- TX write with data-phase ending at edge E: holding loads at E (tx_ready=0), FSM enters START and UART_TX falls at E+1; tx_ready=1 again at E+1.
- Frame length 10×DIVISOR cycles; back-to-back bytes have no idle gap.
- RX byte visible in STATUS[1] the cycle after stop-bit sample; synchronizer adds 2 cycles of input latency.

## Test plan
- Reset: read STATUS -> 0x01; DIVISOR -> 434 (0x1B2); UART_TX=1.
- DIVISOR=16, write DATA 0xA5 -> UART_TX low 16 cycles, then 1,0,1,0,0,1,0,1 each 16 cycles, stop high; tx_busy=1 throughout.
- Two back-to-back writes 0x55, 0x0F with DIVISOR=16 -> second loads holding, frames contiguous (320 cycles), third write while tx_ready=0 dropped.
- Loopback UART_TX→UART_RX, send 0x3C -> STATUS[1]=1, DATA read returns 0x3C, STATUS then 0x01.
- Drive 5 frames into 4-entry FIFO without reads -> STATUS[2]=1, reads return first 4 bytes; write 0x4 to STATUS clears overrun.
- Stop bit driven 0 -> frame_err=1, FIFO empty; 4-cycle low glitch on UART_RX with DIVISOR=16 -> no byte, no error; assert HRESETn low mid-TX -> UART_TX=1 next cycle.

Source files
------------

// File: rtl/mfp_ahb_uart_slave.sv
// AHB-Lite 8N1 UART slave: zero-wait-state register file, double-buffered TX, RX with small FIFO.
// Reads return data registered at the address-phase edge; writes land at the data-phase edge.
module mfp_ahb_uart_slave #(
  parameter int DEFAULT_DIV = 434,
  parameter int RX_FIFO_AW  = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int              DEPTH   = 1 << RX_FIFO_AW;
  localparam logic [RX_FIFO_AW:0] FULL_CNT = (RX_FIFO_AW+1)'(DEPTH);
  localparam logic [15:0]     MIN_DIV = 16'd16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS[0],
                       HWDATA[31:16], SI_Endian};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // Bus state
  logic        wr_pend;
  logic [1:0]  wr_addr;
  logic [15:0] divisor;
  logic        ovr, ferr;

  // TX state
  logic       hold_vld;
  logic [7:0] hold_dat;
  logic [1:0] tx_state;
  logic [15:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_q;

  // RX state
  logic       rx_s1, rx_s2, rx_prev;
  logic [1:0] rx_state;
  logic [15:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;

  // RX FIFO
  logic [7:0]            fifo_mem [0:DEPTH-1];
  logic [RX_FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [RX_FIFO_AW:0]   count;

  logic acc, rd_acc, pop, push, fe_evt, full, do_push, ovr_evt;
  logic tx_wr, st_wr, div_wr, rx_valid, tx_ready, tx_busy;
  logic [31:0] rd_val;

  assign acc      = HSEL & HTRANS[1];
  assign rd_acc   = acc & ~HWRITE;
  assign rx_valid = (count != '0);
  assign tx_ready = ~hold_vld;
  assign tx_busy  = (tx_state != S_IDLE);
  assign full     = (count == FULL_CNT);

  assign pop      = rd_acc & (HADDR[3:2] == 2'd0) & rx_valid;
  assign push     = (rx_state == S_STOP) & (rx_cnt == 16'd0) & rx_s2;
  assign fe_evt   = (rx_state == S_STOP) & (rx_cnt == 16'd0) & ~rx_s2;
  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign do_push  = push & (~full | pop);
  assign ovr_evt  = push & full & ~pop;

  assign tx_wr  = wr_pend & (wr_addr == 2'd0);
  assign st_wr  = wr_pend & (wr_addr == 2'd1);
  assign div_wr = wr_pend & (wr_addr == 2'd2);

  assign UART_TX = tx_q;

  always_comb begin
    rd_val = '0;
    case (HADDR[3:2])
      2'd0:    if (rx_valid) rd_val = {24'd0, fifo_mem[rd_ptr]};
      2'd1:    rd_val = {27'd0, tx_busy, ferr, ovr, rx_valid, tx_ready};
      2'd2:    rd_val = {16'd0, divisor};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      wr_addr <= 2'd0;
      HRDATA  <= '0;
      divisor <= 16'(DEFAULT_DIV);
      ovr     <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      wr_pend <= acc & HWRITE;
      wr_addr <= HADDR[3:2];
      if (rd_acc) HRDATA <= rd_val;
      if (div_wr) divisor <= (HWDATA[15:0] < MIN_DIV) ? MIN_DIV : HWDATA[15:0];
      if (ovr_evt) ovr <= 1'b1;
      else if (st_wr && HWDATA[2]) ovr <= 1'b0;
      if (fe_evt) ferr <= 1'b1;
      else if (st_wr && HWDATA[3]) ferr <= 1'b0;
    end
  end

  // Transmitter: each bit reloads its counter from the live divisor.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_vld <= 1'b0;
      hold_dat <= 8'd0;
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      if (tx_wr && !hold_vld) begin
        hold_vld <= 1'b1;
        hold_dat <= HWDATA[7:0];
      end
      case (tx_state)
        S_IDLE: begin
          if (hold_vld) begin
            tx_state <= S_START;
            hold_vld <= 1'b0;
            tx_sh    <= hold_dat;
            tx_cnt   <= divisor - 16'd1;
            tx_q     <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= S_DATA;
            tx_cnt   <= divisor - 16'd1;
            tx_bit   <= 3'd0;
            tx_q     <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= divisor - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx_q     <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_q   <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= divisor - 16'd1;
            if (hold_vld) begin
              tx_state <= S_START;
              hold_vld <= 1'b0;
              tx_sh    <= hold_dat;
              tx_q     <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // Receiver: half-bit delay after the falling edge puts every later sample mid-bit.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_s1   <= UART_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= {1'b0, divisor[15:1]} - 16'd1;
          end
        end
        S_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= divisor - 16'd1;
              rx_bit   <= 3'd0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= divisor - 16'd1;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_cnt == 16'd0) rx_state <= S_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) fifo_mem[wr_ptr] <= rx_sh;
  end

endmodule

// File: tb/tb_mfp_ahb_uart_slave.sv
// Directed bench for mfp_ahb_uart_slave: register access, TX waveform, RX/FIFO, error flags, reset.
module tb_mfp_ahb_uart_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        SI_Endian;
  logic        UART_RX;
  logic        UART_TX;

  logic        loop_en;
  logic        rx_drv;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  assign UART_RX = loop_en ? UART_TX : rx_drv;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  mfp_ahb_uart_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSIZE(HSIZE), .HSEL(HSEL), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .SI_Endian(SI_Endian), .UART_RX(UART_RX), .UART_TX(UART_TX)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge HCLK);
  endtask

  // Drives one 8N1 frame at 16 cycles per bit.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (16) @(negedge HCLK);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [9:0]  fr;
    logic [7:0]  exp_fifo [4];
    int          t0;

    HRESETn = 1'b0; HADDR = '0; HBURST = '0; HMASTLOCK = 1'b0; HPROT = '0; HSIZE = 3'd2;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = '0; HWRITE = 1'b0; SI_Endian = 1'b0;
    loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hready", {31'd0, HREADY}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_tx", {31'd0, UART_TX}, 32'd1);
    HRESETn = 1'b1;

    ahb_read(2'd1, rd); check("rst_status", rd, 32'h01);
    ahb_read(2'd2, rd); check("rst_div", rd, 32'h1B2);
    ahb_read(2'd3, rd); check("reg3_read", rd, 32'h0);
    ahb_read(2'd0, rd); check("empty_data", rd, 32'h0);

    // DIVISOR floor, then pipelined write-then-read sees the old value.
    ahb_write(2'd2, 32'd5);
    ahb_read(2'd2, rd); check("div_floor", rd, 32'd16);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8;
    @(negedge HCLK);
    HWRITE = 1'b0; HWDATA = 32'd20;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    check("wr_rd_old", HRDATA, 32'd16);
    ahb_read(2'd2, rd); check("wr_rd_new", rd, 32'd20);
    ahb_write(2'd2, 32'd16);

    // Single TX frame 0xA5
    ahb_write(2'd0, 32'hA5);
    t0 = cyc + 2;
    ahb_read(2'd1, rd); check("tx_hold_full", rd, 32'h00);
    ahb_read(2'd1, rd); check("tx_busy_mid", rd, 32'h11);
    fr = {1'b1, 8'hA5, 1'b0};
    wait_to(t0 + 15); check("tx_start_end", {31'd0, UART_TX}, {31'd0, fr[0]});
    for (int k = 0; k < 10; k++) begin
      wait_to(t0 + 16*k + 8);
      check($sformatf("tx_a5_bit%0d", k), {31'd0, UART_TX}, {31'd0, fr[k]});
    end
    wait_to(t0 + 161);
    check("tx_idle_after", {31'd0, UART_TX}, 32'd1);
    ahb_read(2'd1, rd); check("tx_done_status", rd, 32'h01);

    // Back-to-back 0x55, 0x0F; third write dropped
    ahb_write(2'd0, 32'h55);
    t0 = cyc + 2;
    ahb_write(2'd0, 32'h0F);
    ahb_write(2'd0, 32'h99);
    ahb_read(2'd1, rd); check("b2b_status", rd, 32'h10);
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h55 : 8'h0F;
      fr = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        wait_to(t0 + 160*f + 16*k + 8);
        check($sformatf("b2b_f%0d_bit%0d", f, k), {31'd0, UART_TX}, {31'd0, fr[k]});
      end
    end
    wait_to(t0 + 328);
    check("b2b_no_third", {31'd0, UART_TX}, 32'd1);
    ahb_read(2'd1, rd); check("b2b_done", rd, 32'h01);

    // Loopback 0x3C
    loop_en = 1'b1;
    ahb_write(2'd0, 32'h3C);
    t0 = cyc + 2;
    wait_to(t0 + 175);
    ahb_read(2'd1, rd); check("lb_status", rd, 32'h03);
    ahb_read(2'd0, rd); check("lb_data", rd, 32'h3C);
    ahb_read(2'd1, rd); check("lb_status_after", rd, 32'h01);
    loop_en = 1'b0;

    // Five frames into a four-entry FIFO
    exp_fifo[0] = 8'h11; exp_fifo[1] = 8'h22; exp_fifo[2] = 8'h33; exp_fifo[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_byte(exp_fifo[i], 1'b1);
    send_byte(8'h55, 1'b1);
    rx_drv = 1'b1;
    repeat (20) @(negedge HCLK);
    ahb_read(2'd1, rd); check("ovr_status", rd, 32'h07);
    for (int i = 0; i < 4; i++) begin
      ahb_read(2'd0, rd);
      check($sformatf("ovr_data%0d", i), rd, {24'd0, exp_fifo[i]});
    end
    ahb_read(2'd1, rd); check("ovr_drained", rd, 32'h05);
    ahb_write(2'd1, 32'h4);
    ahb_read(2'd1, rd); check("ovr_cleared", rd, 32'h01);

    // Framing error
    send_byte(8'hAA, 1'b0);
    rx_drv = 1'b1;
    repeat (20) @(negedge HCLK);
    ahb_read(2'd1, rd); check("ferr_status", rd, 32'h09);
    ahb_write(2'd1, 32'h8);
    ahb_read(2'd1, rd); check("ferr_cleared", rd, 32'h01);

    // Short glitch
    rx_drv = 1'b0;
    repeat (4) @(negedge HCLK);
    rx_drv = 1'b1;
    repeat (40) @(negedge HCLK);
    ahb_read(2'd1, rd); check("glitch_status", rd, 32'h01);

    // Reset mid-TX
    ahb_write(2'd0, 32'h00);
    t0 = cyc + 2;
    wait_to(t0 + 40);
    check("mid_tx_low", {31'd0, UART_TX}, 32'd0);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst_tx_high", {31'd0, UART_TX}, 32'd1);
    check("rst_hrdata2", HRDATA, 32'h0);
    HRESETn = 1'b1;
    ahb_read(2'd2, rd); check("rst2_div", rd, 32'h1B2);
    ahb_read(2'd1, rd); check("rst2_status", rd, 32'h01);
    repeat (20) @(negedge HCLK);
    check("rst2_tx_idle", {31'd0, UART_TX}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
